// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART transceiver.
package uart_pkg;
  localparam int OSR        = 16;
  localparam int FRAME_BITS = 11;
  localparam int DIV_W      = 14;

  // Clocks per oversampling tick at 50 MHz, indexed by baud_select.
  localparam logic [DIV_W-1:0] BAUD_DIV [8] = '{
    14'd10417, 14'd2604, 14'd651, 14'd326,
    14'd163,   14'd81,   14'd54,  14'd27
  };

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-clock tick every BAUD_DIV[baud_select] clocks.
// Clear restarts the period; a divisor change applies from the next tick.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       clear,
  output logic       tick
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;

  assign div  = BAUD_DIV[baud_select];
  // >= so a smaller divisor selected mid-period wraps immediately.
  assign tick = (cnt >= div - DIV_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (clear || tick)  cnt <= '0;
    else                     cnt <= cnt + DIV_W'(1);
  end
endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1+even-parity UART, 16x oversampling, independent tx/rx baud counters.
// UART_LOOPBACK_EN: receiver input is taken from tx_d instead of the rx_d port.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = uart_pkg::OSR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        baud_select,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  input  logic              tx_en,
  output logic              tx_d,
  output logic              tx_busy,
  input  logic              rx_en,
  input  logic              rx_d,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_ferror,
  output logic              rx_perror,
  output logic              rx_valid
);
  localparam int TCW = $clog2(OSR);
  localparam int BW  = $clog2(DATA_W);

  tx_state_t         tx_state, tx_state_nxt;
  logic [TCW-1:0]    tx_tcnt, tx_tcnt_nxt;
  logic [BW-1:0]     tx_bit, tx_bit_nxt;
  logic [DATA_W-1:0] tx_shreg, tx_shreg_nxt;
  logic              tx_tick, tx_clr, tx_accept, tx_bit_end;

  rx_state_t         rx_state, rx_state_nxt;
  logic [TCW-1:0]    rx_tcnt, rx_tcnt_nxt;
  logic [BW-1:0]     rx_bit, rx_bit_nxt;
  logic [DATA_W-1:0] rx_shreg, rx_shreg_nxt, rx_data_nxt;
  logic              rx_par, rx_par_nxt, rx_wait, rx_wait_nxt;
  logic              rx_ferror_nxt, rx_perror_nxt, rx_valid_nxt;
  logic              rx_tick, rx_clr, rx_bit_end, rx_in, rx_meta, rx_s;

  uart_baud_gen u_tx_baud (.clock(clock), .reset(reset), .baud_select(baud_select),
                           .clear(tx_clr), .tick(tx_tick));
  uart_baud_gen u_rx_baud (.clock(clock), .reset(reset), .baud_select(baud_select),
                           .clear(rx_clr), .tick(rx_tick));

  always_comb begin
    tx_state_nxt = tx_state;
    tx_tcnt_nxt  = tx_tick ? tx_tcnt + TCW'(1) : tx_tcnt;
    tx_bit_nxt   = tx_bit;
    tx_shreg_nxt = tx_shreg;
    tx_clr       = 1'b0;
    tx_accept    = tx_wr && tx_en;
    tx_bit_end   = tx_tick && (tx_tcnt == TCW'(OSR-1));
    case (tx_state)
      TX_IDLE:   if (tx_accept) begin
                   tx_state_nxt = TX_START; tx_shreg_nxt = tx_data;
                   tx_tcnt_nxt = '0; tx_clr = 1'b1;
                 end
      TX_START:  if (tx_bit_end) begin tx_state_nxt = TX_DATA; tx_bit_nxt = '0; end
      TX_DATA:   if (tx_bit_end) begin
                   if (tx_bit == BW'(DATA_W-1)) tx_state_nxt = TX_PARITY;
                   else                         tx_bit_nxt = tx_bit + BW'(1);
                 end
      TX_PARITY: if (tx_bit_end) tx_state_nxt = TX_STOP;
      TX_STOP:   if (tx_bit_end) begin
                   // A still-asserted write chains the next frame with no idle bit.
                   if (tx_accept) begin
                     tx_state_nxt = TX_START; tx_shreg_nxt = tx_data;
                     tx_tcnt_nxt = '0; tx_clr = 1'b1;
                   end else begin
                     tx_state_nxt = TX_IDLE;
                   end
                 end
      default:   tx_state_nxt = TX_IDLE;
    endcase
    if (!tx_en) tx_state_nxt = TX_IDLE;
  end

  always_comb begin
    case (tx_state)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shreg[tx_bit];
      TX_PARITY: tx_d = ^tx_shreg;
      default:   tx_d = 1'b1;
    endcase
  end
  assign tx_busy = (tx_state != TX_IDLE);

`ifdef UART_LOOPBACK_EN
  assign rx_in = tx_d;
`else
  assign rx_in = rx_d;
`endif

  always_comb begin
    rx_state_nxt  = rx_state;
    rx_tcnt_nxt   = rx_tick ? rx_tcnt + TCW'(1) : rx_tcnt;
    rx_bit_nxt    = rx_bit;
    rx_shreg_nxt  = rx_shreg;
    rx_par_nxt    = rx_par;
    rx_data_nxt   = rx_data;
    rx_ferror_nxt = rx_ferror;
    rx_perror_nxt = rx_perror;
    rx_valid_nxt  = 1'b0;
    // After a framing error the line may still be low; wait for idle before re-arming.
    rx_wait_nxt   = rx_wait && !rx_s;
    rx_clr        = 1'b0;
    rx_bit_end    = rx_tick && (rx_tcnt == TCW'(OSR-1));
    case (rx_state)
      RX_IDLE:   if (rx_en && !rx_s && !rx_wait) begin
                   rx_state_nxt = RX_START; rx_tcnt_nxt = '0; rx_clr = 1'b1;
                   rx_ferror_nxt = 1'b0; rx_perror_nxt = 1'b0;
                 end
      RX_START:  if (rx_tick && rx_tcnt == TCW'(OSR/2-1)) begin
                   rx_tcnt_nxt  = '0;
                   rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
                   rx_bit_nxt   = '0;
                 end
      RX_DATA:   if (rx_bit_end) begin
                   rx_shreg_nxt = {rx_s, rx_shreg[DATA_W-1:1]};
                   if (rx_bit == BW'(DATA_W-1)) rx_state_nxt = RX_PARITY;
                   else                         rx_bit_nxt = rx_bit + BW'(1);
                 end
      RX_PARITY: if (rx_bit_end) begin rx_par_nxt = rx_s; rx_state_nxt = RX_STOP; end
      RX_STOP:   if (rx_bit_end) begin
                   rx_data_nxt   = rx_shreg;
                   rx_perror_nxt = (rx_par != ^rx_shreg);
                   rx_ferror_nxt = !rx_s;
                   rx_valid_nxt  = rx_s && (rx_par == ^rx_shreg);
                   rx_wait_nxt   = !rx_s;
                   rx_state_nxt  = RX_IDLE;
                 end
      default:   rx_state_nxt = RX_IDLE;
    endcase
    if (!rx_en) rx_state_nxt = RX_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;  tx_tcnt <= '0; tx_bit <= '0; tx_shreg <= '0;
      rx_state <= RX_IDLE;  rx_tcnt <= '0; rx_bit <= '0; rx_shreg <= '0;
      rx_par   <= 1'b0;     rx_wait <= 1'b0;
      rx_meta  <= 1'b1;     rx_s    <= 1'b1;
      rx_data  <= '0; rx_ferror <= 1'b0; rx_perror <= 1'b0; rx_valid <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt; tx_tcnt <= tx_tcnt_nxt;
      tx_bit   <= tx_bit_nxt;   tx_shreg <= tx_shreg_nxt;
      rx_state <= rx_state_nxt; rx_tcnt <= rx_tcnt_nxt;
      rx_bit   <= rx_bit_nxt;   rx_shreg <= rx_shreg_nxt;
      rx_par   <= rx_par_nxt;   rx_wait  <= rx_wait_nxt;
      rx_meta  <= rx_in;        rx_s     <= rx_meta;
      rx_data  <= rx_data_nxt;  rx_ferror <= rx_ferror_nxt;
      rx_perror <= rx_perror_nxt; rx_valid <= rx_valid_nxt;
    end
  end
endmodule

// File: tb/tb_uart_transceiver.sv
// Randomized self-checking bench: serial frames compared against a bit-level frame model.
module tb_uart_transceiver;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] baud_select = 3'b111;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr = 1'b0, tx_en = 1'b1, rx_en = 1'b1;
  logic       tx_d, tx_busy, rx_d;
  logic [7:0] rx_data;
  logic       rx_ferror, rx_perror, rx_valid;
  logic       loop = 1'b0, rx_drv = 1'b1;
  int         n_chk = 0, n_err = 0, n_valid = 0;

  assign rx_d = loop ? tx_d : rx_drv;
  always #10 clock = ~clock;
  always @(negedge clock) if (rx_valid === 1'b1) n_valid++;

  uart_transceiver dut (
    .clock(clock), .reset(reset), .baud_select(baud_select),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_en(tx_en), .tx_d(tx_d), .tx_busy(tx_busy),
    .rx_en(rx_en), .rx_d(rx_d), .rx_data(rx_data),
    .rx_ferror(rx_ferror), .rx_perror(rx_perror), .rx_valid(rx_valid)
  );

  // Clocks per bit: 16 ticks times the divisor for the selected rate.
  function automatic int bit_len(input logic [2:0] sel);
    case (sel)
      3'd0: return 16 * 10417;  3'd1: return 16 * 2604;
      3'd2: return 16 * 651;    3'd3: return 16 * 326;
      3'd4: return 16 * 163;    3'd5: return 16 * 81;
      3'd6: return 16 * 54;     default: return 16 * 27;
    endcase
  endfunction

  // Line levels in send order: index 0 is the start bit, index 10 the stop bit.
  function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_tx(input logic [7:0] b);
    tx_data = b; tx_wr = 1'b1;
    @(posedge clock); @(negedge clock);
    tx_wr = 1'b0;
  endtask

  // Each bit must hold one level for exactly blen clocks.
  task automatic watch_tx(input string tag, input logic [21:0] exp, input int nbits, input int blen);
    int t; logic first; bit stable;
    t = 0;
    while (tx_d !== 1'b0 && t < 40000) begin @(negedge clock); t++; end
    if (tx_d !== 1'b0) begin chk({tag, "_start_timeout"}, 32'(tx_d), 32'd0); return; end
    for (int i = 0; i < nbits; i++) begin
      first = tx_d; stable = 1'b1;
      for (int c = 0; c < blen; c++) begin
        if (tx_d !== first) stable = 1'b0;
        @(negedge clock);
      end
      chk(tag, stable ? 32'(first) : 32'd2, 32'(exp[i]));
    end
  endtask

  task automatic watch_busy(input string tag, input int exp_len);
    int t, cnt;
    t = 0; cnt = 0;
    while (tx_busy !== 1'b1 && t < 1000) begin @(negedge clock); t++; end
    while (tx_busy === 1'b1 && cnt < 40000) begin cnt++; @(negedge clock); end
    chk(tag, 32'(cnt), 32'(exp_len));
  endtask

  task automatic drive_rx(input logic [10:0] f, input int blen);
    for (int i = 0; i < 11; i++) begin
      rx_drv = f[i];
      repeat (blen) @(negedge clock);
    end
    rx_drv = 1'b1;
  endtask

  task automatic check_rx(input string tag, input logic [7:0] b, input logic pe, input logic fe,
                          input int v0, input int nv);
    chk({tag, "_data"}, 32'(rx_data), 32'(b));
    chk({tag, "_perror"}, 32'(rx_perror), 32'(pe));
    chk({tag, "_ferror"}, 32'(rx_ferror), 32'(fe));
    chk({tag, "_valid_cnt"}, 32'(n_valid - v0), 32'(nv));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blen, v0;
    logic [7:0] b, b2, last_b;
    bit bp, bs;

    repeat (3) @(negedge clock);
    chk("rst_tx_d", 32'(tx_d), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_ferror", 32'(rx_ferror), 32'd0);
    chk("rst_rx_perror", 32'(rx_perror), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // External loopback of 0xDD at the fastest rate.
    loop = 1'b1; baud_select = 3'b111; blen = bit_len(baud_select); v0 = n_valid;
    fork
      send_tx(8'hDD);
      watch_tx("lb_dd_bit", {11'd0, frame_of(8'hDD, 1'b0, 1'b0)}, 11, blen);
      watch_busy("lb_dd_busy_len", 11 * blen);
    join
    repeat (10) @(negedge clock);
    check_rx("lb_dd", 8'hDD, 1'b0, 1'b0, v0, 1);
    loop = 1'b0;

    // Wrong parity at 57600.
    baud_select = 3'b110; blen = bit_len(baud_select); v0 = n_valid;
    drive_rx(frame_of(8'h3C, 1'b1, 1'b0), blen);
    repeat (blen) @(negedge clock);
    check_rx("perr", 8'h3C, 1'b1, 1'b0, v0, 0);

    // Framing error, then a good frame clears it.
    baud_select = 3'b111; blen = bit_len(baud_select);
    b = 8'($urandom); v0 = n_valid;
    drive_rx(frame_of(b, 1'b0, 1'b1), blen);
    repeat (blen) @(negedge clock);
    check_rx("ferr", b, 1'b0, 1'b1, v0, 0);
    b = 8'($urandom); v0 = n_valid;
    drive_rx(frame_of(b, 1'b0, 1'b0), blen);
    repeat (blen) @(negedge clock);
    check_rx("after_ferr", b, 1'b0, 1'b0, v0, 1);
    last_b = b;

    // 5-tick glitch must be rejected as a false start.
    v0 = n_valid; rx_drv = 1'b0;
    repeat (5 * 27) @(negedge clock);
    rx_drv = 1'b1;
    repeat (2 * blen) @(negedge clock);
    check_rx("false_start", last_b, 1'b0, 1'b0, v0, 0);

    // Random frames with random parity/stop corruption.
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom); bp = 1'($urandom_range(0, 1)); bs = 1'($urandom_range(0, 1));
      v0 = n_valid;
      drive_rx(frame_of(b, bp, bs), blen);
      repeat (blen) @(negedge clock);
      check_rx("rand_rx", b, bp, bs, v0, (!bp && !bs) ? 1 : 0);
    end

    // Random bytes through the external loop.
    loop = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom); v0 = n_valid;
      fork
        send_tx(b);
        watch_tx("rand_lb_bit", {11'd0, frame_of(b, 1'b0, 1'b0)}, 11, blen);
      join
      repeat (10) @(negedge clock);
      check_rx("rand_lb", b, 1'b0, 1'b0, v0, 1);
    end

    // tx_wr held for two frame times: two frames with no gap.
    b = 8'($urandom); b2 = 8'($urandom); v0 = n_valid;
    tx_data = b; tx_wr = 1'b1;
    fork
      begin
        @(posedge clock); @(negedge clock);
        tx_data = b2;
        repeat (22 * blen - 300) @(negedge clock);
        tx_wr = 1'b0;
      end
      watch_tx("b2b_bit", {frame_of(b2, 1'b0, 1'b0), frame_of(b, 1'b0, 1'b0)}, 22, blen);
    join
    repeat (20) @(negedge clock);
    chk("b2b_busy_after", 32'(tx_busy), 32'd0);
    check_rx("b2b", b2, 1'b0, 1'b0, v0, 2);
    loop = 1'b0;

    // tx_en drop aborts a frame.
    send_tx(8'($urandom));
    repeat (1000) @(negedge clock);
    chk("abort_busy_mid", 32'(tx_busy), 32'd1);
    tx_en = 1'b0;
    @(negedge clock);
    chk("abort_tx_d", 32'(tx_d), 32'd1);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    tx_en = 1'b1;
    repeat (5) @(negedge clock);

    // Reset halfway through a frame, then a clean 0xA5.
    send_tx(8'hA5);
    repeat (5 * blen + blen / 2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_tx_d", 32'(tx_d), 32'd1);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    fork
      send_tx(8'hA5);
      watch_tx("post_rst_a5_bit", {11'd0, frame_of(8'hA5, 1'b0, 1'b0)}, 11, blen);
    join

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8-bit UART with a transmitter path and a receiver path that share one baud_select setting.
- Frame format: start bit, 8 data bits sent LSB first, even parity bit, one stop bit (11 bits total).
- 16x oversampling derived from a 50 MHz clock.
- Sits between a host register interface and the serial pins; the serial output and input are looped back externally in system test.

Parameters:
- DATA_W, 8, data bits per frame; only the value 8 is supported.
- OSR, 16, baud ticks per bit.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- baud_select  in  3  rate select; sampled continuously.
- tx_data  in  8  byte to transmit.
- tx_wr  in  1  write request.
- tx_en  in  1  transmitter enable.
- tx_d  out  1  serial output; idle level is 1.
- tx_busy  out  1  high while a frame is in flight.
- rx_en  in  1  receiver enable.
- rx_d  in  1  serial input.
- rx_data  out  8  last received byte.
- rx_ferror  out  1  framing error.
- rx_perror  out  1  parity error.
- rx_valid  out  1  one-cycle pulse for a good byte.

Behaviour:
- **Reset values:** tx_d=1, tx_busy=0, rx_data=0, rx_ferror=0, rx_perror=0, rx_valid=0. Both state machines go to IDLE.
- **Baud divisor N (clocks per tick)** by baud_select:
  - 000 → 10417 (300 baud)
  - 001 → 2604 (1200)
  - 010 → 651 (4800)
  - 011 → 326 (9600)
  - 100 → 163 (19200)
  - 101 → 81 (38400)
  - 110 → 54 (57600)
  - 111 → 27 (115200)
- **Baud counters:** each path has its own counter. It emits a one-clock tick every N clocks and is cleared at frame start. One bit time is exactly 16·N clocks.
- **Tx acceptance:** a write is accepted on a clock where tx_wr=1, tx_en=1 and tx_busy=0. tx_data is latched on that clock. tx_busy rises and tx_d=0 (start bit) on the next clock.
- **Tx state machine:** IDLE → START → DATA(bit 0..7, LSB first) → PARITY → STOP → IDLE.
  - Each state lasts 16 ticks.
  - Parity bit = XOR of the 8 data bits (even parity).
  - tx_busy falls on the clock the STOP state ends.
  - If tx_wr is still high at that point, the next frame is accepted immediately (back-to-back frames).
- **Tx disable:** tx_en=0 at any time aborts the frame, returns to IDLE, drives tx_d=1 and clears tx_busy.
- **Rx input sync:** rx_d passes through a 2-flop synchronizer; all decisions use the synchronized value.
- **Rx state machine:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - In IDLE with rx_en=1, a low level clears the counter and enters START.
  - After 8 ticks the start bit is re-checked. If it is high, this is a false start: return to IDLE with no flags changed.
  - Each following bit is sampled every 16 ticks, i.e. mid-bit.
- **Rx end of frame (at the stop-bit sample):**
  - rx_data is loaded with the received byte.
  - rx_perror = (received parity ≠ XOR of the data).
  - rx_ferror = (stop sample == 0).
  - rx_valid pulses for one clock only if both flags are 0.
  - The error flags hold until the next START entry, which clears them.
- **Rx disable:** rx_en=0 aborts to IDLE; rx_data and the flags keep their values.
- **baud_select change mid-frame:** takes effect at the next tick; no glitch protection is required.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: the receiver input is internally taken from the transmitter output (tx_d) and the rx_d port is ignored.
- Undefined: the receiver uses rx_d.

Decomposition:
- Package uart_pkg holds:
  - the divisor constant table indexed by baud_select;
  - the tx and rx state enums;
  - the frame constants OSR=16 and FRAME_BITS=11.
- Sub-module uart_baud_gen (divisor counter with clear input, tick output) is instantiated once per path.

Test Plan:
- **Loopback, baud 111, tx_data=0xDD, one tx_wr:**
  - tx_d sequence is 0,1,0,1,1,1,0,1,1,0,1, each bit 432 clocks.
  - rx_valid pulses once and rx_data=0xDD with both error flags 0.
  - tx_busy is high for 4752 clocks.
- **Baud 110, rx_d driven with 0x3C and parity bit 1 (wrong):** rx_perror=1, rx_valid stays 0, rx_data=0x3C.
- **rx_d frame with stop bit 0:** rx_ferror=1 and no rx_valid. The next good frame clears rx_ferror and pulses rx_valid.
- **False start:** a 5-tick low pulse on idle rx_d produces no flags and the receiver stays in IDLE.
- **Reset mid-frame:** drive reset low halfway through a tx frame → tx_d=1 and tx_busy=0 immediately. After release, a new 0xA5 frame is sent correctly.
- **tx_wr held high for two frame times:** two back-to-back frames are sent with no idle gap between them.
